instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder: turns an op/field request into a 32-bit word
// and writes it to instruction memory at an auto-incrementing word address.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  input  logic        load_base,
  input  logic [9:0]  base_addr,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  input  logic        im_ack,
  output logic [10:0] word_cnt,
  output logic        err,
  output logic        wrapped,
  output logic [4:0]  err_op
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADDU = 5'd1,  OP_SUBU = 5'd2,  OP_SLTU = 5'd3,
    OP_MOVN = 5'd4,  OP_JR   = 5'd5,  OP_ORI  = 5'd6,  OP_LUI  = 5'd7,
    OP_BEQ  = 5'd8,  OP_LW   = 5'd9,  OP_SW   = 5'd10, OP_LBU  = 5'd11,
    OP_LHU  = 5'd12, OP_SB   = 5'd13, OP_SH   = 5'd14, OP_JAL  = 5'd15,
    OP_J    = 5'd16
  } op_e;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state;
  logic        legal;
  logic [31:0] enc;

  function automatic logic [31:0] r_type(input logic [4:0] s, t, d,
                                         input logic [5:0] funct);
    return {6'b0, s, t, d, 5'b0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opc,
                                         input logic [4:0] s, t,
                                         input logic [15:0] im16);
    return {opc, s, t, im16};
  endfunction

  assign in_ready = (state == IDLE) && !load_base;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (op)
      OP_NOP:  enc = '0;
      OP_ADDU: enc = r_type(rs, rt, rd, 6'b100001);
      OP_SUBU: enc = r_type(rs, rt, rd, 6'b100011);
      OP_SLTU: enc = r_type(rs, rt, rd, 6'b101011);
      OP_MOVN: enc = r_type(rs, rt, rd, 6'b001011);
      OP_JR:   enc = r_type(rs, 5'd0, 5'd0, 6'b001000);
      OP_ORI:  enc = i_type(6'b001101, rs, rt, imm[15:0]);
      OP_LUI:  enc = i_type(6'b001111, 5'd0, rt, imm[15:0]);
      OP_BEQ:  enc = i_type(6'b000100, rs, rt, imm[15:0]);
      OP_LW:   enc = i_type(6'b100011, rs, rt, imm[15:0]);
      OP_SW:   enc = i_type(6'b101011, rs, rt, imm[15:0]);
      OP_LBU:  enc = i_type(6'b100100, rs, rt, imm[15:0]);
      OP_LHU:  enc = i_type(6'b100101, rs, rt, imm[15:0]);
      OP_SB:   enc = i_type(6'b101000, rs, rt, imm[15:0]);
      OP_SH:   enc = i_type(6'b101001, rs, rt, imm[15:0]);
      OP_JAL:  enc = {6'b000011, imm};
      OP_J:    enc = {6'b000010, imm};
      default: legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      err_op   <= '0;
      wrapped  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_base) begin
            im_addr <= base_addr;
          end else if (in_valid) begin
            if (legal) begin
              state    <= WRITE;
              im_we    <= 1'b1;
              im_wdata <= enc;
            end else begin
              err <= 1'b1;
              if (!err) err_op <= op;
            end
          end
        end
        WRITE: begin
          // im_addr doubles as the write counter; it only moves once the word lands
          if (im_ack) begin
            state   <= IDLE;
            im_we   <= 1'b0;
            im_addr <= im_addr + 10'd1;
            if (im_addr == 10'h3FF) wrapped <= 1'b1;
            if (word_cnt != 11'h7FF) word_cnt <= word_cnt + 11'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a
// negedge monitor pops and compares each accepted memory write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0, rs = '0, rt = '0, rd = '0;
  logic [25:0] imm = '0;
  logic        load_base = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        im_ack = 1'b1;
  logic [10:0] word_cnt;
  logic        err, wrapped;
  logic [4:0]  err_op;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .load_base(load_base), .base_addr(base_addr),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
    .word_cnt(word_cnt), .err(err), .wrapped(wrapped), .err_op(err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] word;
  } vec_t;

  wr_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          we_cycles = 0;
  int          cyc = 0;
  logic [9:0]  exp_addr = '0;
  logic [10:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (im_we) we_cycles++;

  // Monitor: a write is accepted on the next edge whenever im_we & im_ack.
  always @(negedge clk) begin
    if (reset && im_we && im_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'b0, im_we}, 32'h0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {22'b0, im_addr}, {22'b0, e.addr});
        check("wr_data", im_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [4:0] o, s, t, d, input logic [25:0] im,
                      input bit legal, input logic [31:0] exp_w);
    bit ok = 1'b0;
    op = o; rs = s; rt = t; rd = d; imm = im; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("accept", {31'b0, ok}, 32'h1);
    if (ok && legal) begin
      sb.push_back('{exp_addr, exp_w});
      exp_addr = exp_addr + 10'd1;
      if (exp_cnt != 11'h7FF) exp_cnt = exp_cnt + 11'd1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!im_we) begin ok = 1'b1; break; end
    end
    check("write_done", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    check("rst_im_we",    {31'b0, im_we},    32'h0);
    check("rst_im_addr",  {22'b0, im_addr},  32'h0);
    check("rst_im_wdata", im_wdata,          32'h0);
    check("rst_word_cnt", {21'b0, word_cnt}, 32'h0);
    check("rst_err",      {31'b0, err},      32'h0);
    check("rst_err_op",   {27'b0, err_op},   32'h0);
    check("rst_wrapped",  {31'b0, wrapped},  32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    exp_addr = '0;
    exp_cnt  = '0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[16] = '{
    '{5'd0,  32'h0000_0000}, '{5'd1,  32'h0022_1821}, '{5'd2,  32'h0022_1823},
    '{5'd3,  32'h0022_182B}, '{5'd4,  32'h0022_180B}, '{5'd5,  32'h0020_0008},
    '{5'd6,  32'h3422_ABCD}, '{5'd7,  32'h3C02_ABCD}, '{5'd8,  32'h1022_ABCD},
    '{5'd9,  32'h8C22_ABCD}, '{5'd10, 32'hAC22_ABCD}, '{5'd11, 32'h9022_ABCD},
    '{5'd12, 32'h9422_ABCD}, '{5'd13, 32'hA022_ABCD}, '{5'd14, 32'hA422_ABCD},
    '{5'd16, 32'h0BFF_ABCD}
  };

  initial begin
    int we0, c0;
    logic [9:0] hold_addr;

    #2;
    check_reset_state();
    #10 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // addu, ack tied high: single-cycle strobe, word_cnt becomes 1
    we0 = we_cycles;
    send(5'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h0022_1821);
    wait_idle();
    check("addu_we_cycles", we_cycles - we0, 32'd1);
    check("addu_word_cnt", {21'b0, word_cnt}, 32'd1);

    // ori / lui from a fresh reset land at addresses 0 and 1
    do_reset();
    send(5'd6, 5'd0, 5'd8, 5'd0, 26'h1234, 1'b1, 32'h3408_1234);
    send(5'd7, 5'd5, 5'd1, 5'd0, 26'hFFFF, 1'b1, 32'h3C01_FFFF);
    wait_idle();
    check("ori_lui_addr", {22'b0, im_addr}, 32'd2);

    // every legal op back to back, upper imm bits set, plus throughput
    c0 = cyc;
    foreach (vecs[i]) send(vecs[i].op, 5'd1, 5'd2, 5'd3, 26'h3FF_ABCD, 1'b1, vecs[i].word);
    wait_idle();
    check("throughput", {31'b0, (cyc - c0) <= 35}, 32'h1);
    check("table_word_cnt", {21'b0, word_cnt}, {21'b0, exp_cnt});

    // jal with im_ack low for 3 cycles; load_base in WRITE must be ignored
    im_ack = 1'b0;
    hold_addr = exp_addr;
    send(5'd15, 5'd0, 5'd0, 5'd0, 26'h000_0100, 1'b1, 32'h0C00_0100);
    load_base = 1'b1;
    base_addr = 10'h155;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_we",    {31'b0, im_we},    32'h1);
      check("hold_addr",  {22'b0, im_addr},  {22'b0, hold_addr});
      check("hold_wdata", im_wdata,          32'h0C00_0100);
      check("hold_ready", {31'b0, in_ready}, 32'h0);
    end
    @(posedge clk); #1;
    im_ack = 1'b1;
    load_base = 1'b0;
    wait_idle();
    check("jal_addr_after", {22'b0, im_addr}, {22'b0, hold_addr + 10'd1});
    check("idle_wdata_held", im_wdata, 32'h0C00_0100);
    check("wrapped_before", {31'b0, wrapped}, 32'h0);

    // load_base beats a simultaneous request, then a nop at 0x3FF wraps
    load_base = 1'b1;
    base_addr = 10'h3FF;
    op = 5'd1; in_valid = 1'b1;
    @(negedge clk);
    check("load_ready_low", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    load_base = 1'b0;
    in_valid = 1'b0;
    exp_addr = 10'h3FF;
    @(negedge clk);
    check("load_no_write", {31'b0, im_we}, 32'h0);
    check("load_addr", {22'b0, im_addr}, 32'h3FF);
    @(posedge clk); #1;
    send(5'd0, 5'd7, 5'd7, 5'd7, 26'h3FF_FFFF, 1'b1, 32'h0);
    wait_idle();
    check("wrap_addr", {22'b0, im_addr}, 32'h0);
    check("wrapped_set", {31'b0, wrapped}, 32'h1);

    // illegal ops 20 then 25: only the first is captured, nothing written
    check("err_before", {31'b0, err}, 32'h0);
    we0 = we_cycles;
    send(5'd20, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0, 32'h0);
    send(5'd25, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("illegal_err", {31'b0, err}, 32'h1);
    check("illegal_err_op", {27'b0, err_op}, 32'd20);
    check("illegal_word_cnt", {21'b0, word_cnt}, {21'b0, exp_cnt});
    check("illegal_addr", {22'b0, im_addr}, {22'b0, exp_addr});
    check("illegal_no_we", we_cycles - we0, 32'd0);
    check("illegal_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // reset asserted mid-WRITE with im_ack low abandons the write
    im_ack = 1'b0;
    send(5'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h0022_1821);
    check("pre_abort_we", {31'b0, im_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_reset_state();
    check("abort_ready", {31'b0, in_ready}, 32'h1);
    sb.delete();
    exp_addr = '0;
    exp_cnt  = '0;
    im_ack = 1'b1;
    #3 reset = 1'b1;
    @(negedge clk);
    check("ready_after_abort", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // 2048 nops: word_cnt saturates at 2047 and the counter wraps to 0
    for (int i = 0; i < 2048; i++) send(5'd0, 5'd0, 5'd0, 5'd0, 26'h0, 1'b1, 32'h0);
    wait_idle();
    check("sat_word_cnt", {21'b0, word_cnt}, 32'd2047);
    check("sat_addr", {22'b0, im_addr}, 32'h0);
    check("sat_wrapped", {31'b0, wrapped}, 32'h1);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
